mem8to32: RTL and testbench

Byte-to-word assembly memory: the write-side counterpart of the 32-bit-in / byte-out `mem32` store. It accepts single bytes at a 2-bit byte address and fills a 4-byte word image. It flags `valid` once all four lanes hold fresh data and returns the complete 32-bit word on a read. It sits between byte-wide producers (UART/SPI receive paths) and word-wide consumers.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem8to32.sv | 71 +++++++
 tb/tb_mem8to32.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants and lane helper for the byte/word assembly memories.
// No logic of its own; zero latency.
// No flow control; pure definitions.
package mem_pkg;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;
    localparam int ADDR_W = 2;
    localparam int WORD_W = 32;

    // Bit position of the low bit of byte lane 'a' inside the word.
    function automatic logic [4:0] lane_lsb(input logic [ADDR_W-1:0] a);
        return {a, 3'b000};
    endfunction

endpackage

// File: rtl/mem8to32.sv
// Assembles four byte writes into one 32-bit word, flags it full and returns it on a read.
// Latency: valid rises right after the 4th lane write; Dataout/rvalid update one edge after rd.
// Backpressure: writes are dropped (err set) while the word is full, unless a read consumes it in the same cycle.
module mem8to32 #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr,
    input  logic [mem_pkg::ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]             Indata,
    input  logic                          rd,
    output logic [LANES*DATA_W-1:0]       Dataout,
    output logic                          valid,
    output logic                          rvalid,
    output logic                          err
);
    import mem_pkg::*;

    logic [WORD_W-1:0] word, word_nxt;
    logic [LANES-1:0]  mask, mask_nxt;
    logic [LANES-1:0]  lane_en;
    logic              rd_ok;
    logic              wr_ok;
    logic              err_set;

    // The word counts as full only once every lane has been written since the last read.
    assign valid = &mask;

    // Decide which requests are accepted and build the next word image and lane mask.
    always_comb begin
        lane_en  = 4'b0001 << addr;
        rd_ok    = rd && valid;
        // A write is allowed into a partial word, or into a full word that is leaving this cycle.
        wr_ok    = wr && (!valid || rd);
        err_set  = (rd && !valid) || (wr && valid && !rd);
        word_nxt = word;
        mask_nxt = mask;
        if (rd_ok) begin
            mask_nxt = '0;
        end
        if (wr_ok) begin
            // Stale bytes in other lanes stay in place; only the mask tracks freshness.
            word_nxt[lane_lsb(addr) +: BYTE_W] = Indata;
            mask_nxt = (rd_ok ? '0 : mask) | lane_en;
        end
    end

    // State and output registers; reset wins over any same-cycle request.
    always_ff @(posedge clk) begin
        if (rst) begin
            word    <= '0;
            mask    <= '0;
            Dataout <= '0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
        end else begin
            word   <= word_nxt;
            mask   <= mask_nxt;
            rvalid <= rd_ok;
            if (rd_ok) begin
                Dataout <= word;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem8to32.sv
module tb_mem8to32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [7:0]  Indata = 8'h00;
    logic        rd = 1'b0;
    logic [31:0] Dataout;
    logic        valid;
    logic        rvalid;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    mem8to32 dut (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .addr    (addr),
        .Indata  (Indata),
        .rd      (rd),
        .Dataout (Dataout),
        .valid   (valid),
        .rvalid  (rvalid),
        .err     (err)
    );

    always #5 clk = ~clk;

    // One clock cycle of stimulus; outputs are then stable for sampling 1 unit after the edge.
    task automatic step(input logic w, input logic [1:0] a, input logic [7:0] d, input logic r);
        @(negedge clk);
        wr = w; addr = a; Indata = d; rd = r;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; wr = 1'b1; rd = 1'b1; addr = 2'd1; Indata = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; wr = 1'b0; rd = 1'b0;
        n_cmp++; if (Dataout !== 32'h0) begin n_bad++; $display("FAIL reset_dataout: got %h want %h", Dataout, 32'h0); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_in_order();
        step(1, 2'd0, 8'hA1, 0);
        step(1, 2'd1, 8'hB2, 0);
        step(1, 2'd2, 8'hC3, 0);
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL inorder_valid3: got %b want 0", valid); end
        step(1, 2'd3, 8'hD4, 0);
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL inorder_valid4: got %b want 1", valid); end
        step(0, 2'd0, 8'h00, 1);
        n_cmp++; if (Dataout !== 32'hD4C3B2A1) begin n_bad++; $display("FAIL inorder_data: got %h want %h", Dataout, 32'hD4C3B2A1); end
        n_cmp++; if (rvalid !== 1'b1) begin n_bad++; $display("FAIL inorder_rvalid: got %b want 1", rvalid); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL inorder_valid_after_rd: got %b want 0", valid); end
        step(0, 2'd0, 8'h00, 0);
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL inorder_rvalid_pulse: got %b want 0", rvalid); end
        n_cmp++; if (Dataout !== 32'hD4C3B2A1) begin n_bad++; $display("FAIL inorder_data_hold: got %h want %h", Dataout, 32'hD4C3B2A1); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL inorder_err: got %b want 0", err); end
    endtask

    task automatic test_out_of_order();
        logic [1:0] a_tab [5] = '{2'd2, 2'd0, 2'd2, 2'd3, 2'd1};
        logic [7:0] d_tab [5] = '{8'h33, 8'h11, 8'h55, 8'h44, 8'h22};
        for (int i = 0; i < 5; i++) begin
            step(1, a_tab[i], d_tab[i], 0);
            n_cmp++;
            if (valid !== (i == 4)) begin
                n_bad++;
                $display("FAIL ooo_valid_step%0d: got %b want %b", i, valid, (i == 4));
            end
        end
        step(0, 2'd0, 8'h00, 1);
        n_cmp++; if (Dataout !== 32'h44552211) begin n_bad++; $display("FAIL ooo_data: got %h want %h", Dataout, 32'h44552211); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ooo_err: got %b want 0", err); end
    endtask

    task automatic test_overflow();
        step(1, 2'd0, 8'h01, 0);
        step(1, 2'd1, 8'h02, 0);
        step(1, 2'd2, 8'h03, 0);
        step(1, 2'd3, 8'h04, 0);
        step(1, 2'd0, 8'hFF, 0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovf_err: got %b want 1", err); end
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid: got %b want 1", valid); end
        step(0, 2'd0, 8'h00, 1);
        n_cmp++; if (Dataout !== 32'h04030201) begin n_bad++; $display("FAIL ovf_data: got %h want %h", Dataout, 32'h04030201); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) step(1, i[1:0], 8'hFF, 0);
        step(1, 2'd1, 8'h5A, 1);
        n_cmp++; if (Dataout !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL b2b_data: got %h want %h", Dataout, 32'hFFFFFFFF); end
        n_cmp++; if (rvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid: got %b want 1", rvalid); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid: got %b want 0", valid); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_err: got %b want 0", err); end
        step(1, 2'd0, 8'h00, 0);
        step(1, 2'd2, 8'h00, 0);
        step(1, 2'd3, 8'h00, 0);
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_refill: got %b want 1", valid); end
        step(0, 2'd0, 8'h00, 1);
        n_cmp++; if (Dataout !== 32'h00005A00) begin n_bad++; $display("FAIL b2b_data2: got %h want %h", Dataout, 32'h00005A00); end
    endtask

    task automatic test_read_empty_and_reset();
        step(0, 2'd0, 8'h00, 1);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rdempty_err: got %b want 1", err); end
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL rdempty_rvalid: got %b want 0", rvalid); end
        n_cmp++; if (Dataout !== 32'h00005A00) begin n_bad++; $display("FAIL rdempty_data: got %h want %h", Dataout, 32'h00005A00); end
        step(1, 2'd0, 8'h12, 0);
        step(1, 2'd1, 8'h34, 0);
        do_reset();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL midreset_err: got %b want 0", err); end
        n_cmp++; if (Dataout !== 32'h0) begin n_bad++; $display("FAIL midreset_data: got %h want 0", Dataout); end
        step(1, 2'd2, 8'h56, 0);
        step(1, 2'd3, 8'h78, 0);
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b want 0", valid); end
    endtask

    task automatic test_rdwr_not_full();
        do_reset();
        step(1, 2'd0, 8'hAB, 1);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rdwr_empty_err: got %b want 1", err); end
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL rdwr_empty_rvalid: got %b want 0", rvalid); end
        step(1, 2'd1, 8'hCD, 0);
        step(1, 2'd2, 8'hEF, 0);
        step(1, 2'd3, 8'h01, 0);
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL rdwr_empty_valid: got %b want 1", valid); end
        step(0, 2'd0, 8'h00, 1);
        n_cmp++; if (Dataout !== 32'h01EFCDAB) begin n_bad++; $display("FAIL rdwr_empty_data: got %h want %h", Dataout, 32'h01EFCDAB); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_overflow();
        test_back_to_back();
        test_read_empty_and_reset();
        test_rdwr_not_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
